tohost_monitor: RTL and testbench
=================================

TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, the word-aligned byte address of the test-result register.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000, the maximum number of RUN cycles before timeout.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port mem_we, input, 1, core data-store strobe, one store per asserted cycle.
REQ-006 SHALL have port mem_addr, input, 32, core store byte address.
REQ-007 SHALL have port mem_wdata, input, 32, core store data.
REQ-008 SHALL have port mem_wstrb, input, 4, byte enables; bit n enables mem_wdata[8n+7:8n].
REQ-009 SHALL have port done, output, 1, high once the test has ended (pass, fail or timeout).
REQ-010 SHALL have port pass, output, 1, high when the test ended with a tohost value of 1.
REQ-011 SHALL have port fail_test, output, 31, failing test number (tohost value >> 1); zero unless failed.
REQ-012 SHALL have port timeout, output, 1, high when the test ended by timeout.
REQ-013 SHALL have port bad_write, output, 1, sticky flag for a partial-strobe store to TOHOST_ADDR.
REQ-014 SHALL have port cycle_count, output, 32, RUN cycles elapsed, frozen at test end.

Function
REQ-015 SHALL implement FSM states RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are terminal until reset.
REQ-016 SHALL define a hit as mem_we=1 and mem_addr[31:2]==TOHOST_ADDR[31:2]; mem_addr[1:0] is ignored.
REQ-017 SHALL commit a hit only when mem_wstrb==4'hF; any other nonzero strobe on a hit sets bad_write and leaves the FSM unchanged.
REQ-018 SHALL ignore hits with mem_wstrb==0 and hits whose mem_wdata==0 (no commit, no bad_write).
REQ-019 SHALL, on a committed hit with mem_wdata==1 in RUN, move to PASS on the next edge.
REQ-020 SHALL, on a committed hit with mem_wdata[0]==1 and mem_wdata!=1 in RUN, move to FAIL and load fail_test=mem_wdata[31:1].
REQ-021 SHALL, on a committed hit with mem_wdata[0]==0 and mem_wdata!=0, move to FAIL with fail_test=31'h7FFF_FFFF (malformed result).
REQ-022 SHALL drive done, pass and timeout as registered outputs, asserted in the cycle after the committing edge (1-cycle latency).
REQ-023 SHALL increment cycle_count by 1 every cycle in RUN, saturating at 32'hFFFF_FFFF, and hold it in terminal states.
REQ-024 SHALL ignore all stores, including further hits, once in a terminal state; outputs are not updated and bad_write is not set.
REQ-025 SHALL give a committed hit priority over timeout when both occur on the same edge.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, enter RUN and clear done, pass, fail_test, timeout, bad_write and cycle_count to 0.
REQ-027 SHALL treat reset asserted in any state, including mid-run or terminal, identically; a store in a reset cycle is discarded.
REQ-028 SHALL start counting on the first edge with rst=0 after reset.

Configuration
REQ-029 SHALL compile the watchdog only when macro TOHOST_MONITOR_TIMEOUT_EN is defined.
REQ-030 SHALL, with TOHOST_MONITOR_TIMEOUT_EN defined, move RUN to TIMEOUT on the edge where cycle_count reaches TIMEOUT_CYCLES with no commit; done=1, timeout=1, pass=0.
REQ-031 SHALL, without TOHOST_MONITOR_TIMEOUT_EN, never enter TIMEOUT; timeout is tied to 0 and RUN persists until a commit.

Verification
REQ-032 SHALL cover: reset, then after 10 cycles store 32'h1 with wstrb 4'hF to 32'h1000 -> next cycle done=1, pass=1, fail_test=0, cycle_count=11.
REQ-033 SHALL cover: store 32'h7 with wstrb 4'hF to 32'h1000 -> done=1, pass=0, fail_test=3; later store 32'h1 -> outputs unchanged.
REQ-034 SHALL cover: store 32'h1 with wstrb 4'h3 to 32'h1002 -> bad_write=1, done=0; following full store 32'h1 -> pass=1, bad_write stays 1.
REQ-035 SHALL cover: with TOHOST_MONITOR_TIMEOUT_EN and TIMEOUT_CYCLES=20, no stores -> done=1, timeout=1 after 20 cycles, cycle_count=20; without the macro, done=0 after 100 cycles.
REQ-036 SHALL cover: store 32'h1 to 32'h1004 and to 32'h1000 with wstrb 0 -> no effect; rst pulse while in PASS -> all outputs 0, RUN resumes.

Source files
------------

// File: rtl/tohost_monitor.sv
// Watches core stores to the tohost word and latches the test verdict (pass / fail / timeout).
// The watchdog is built only when TOHOST_MONITOR_TIMEOUT_EN is defined.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_test,
  output logic        timeout,
  output logic        bad_write,
  output logic [31:0] cycle_count
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_PASS    = 2'd1;
  localparam logic [1:0] S_FAIL    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  logic [1:0]  state;
  logic        running, hit, commit, partial, expire;
  logic [31:0] cnt_next;
  logic [1:0]  unused_addr_lsb;

  // Byte offset within the tohost word is irrelevant.
  assign unused_addr_lsb = mem_addr[1:0];

  assign running  = (state == S_RUN);
  // Zero-valued stores never count, whatever the strobe.
  assign hit      = mem_we && (mem_addr[31:2] == TOHOST_ADDR[31:2]) && (mem_wdata != 32'd0);
  assign commit   = running && hit && (mem_wstrb == 4'hF);
  assign partial  = running && hit && (mem_wstrb != 4'h0) && (mem_wstrb != 4'hF);
  assign cnt_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

`ifdef TOHOST_MONITOR_TIMEOUT_EN
  logic timeout_q;
  assign expire  = running && (cnt_next == TIMEOUT_CYCLES[31:0]);
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst)
      timeout_q <= 1'b0;
    else if (expire && !commit)
      timeout_q <= 1'b1;
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_test   <= 31'd0;
      bad_write   <= 1'b0;
      cycle_count <= 32'd0;
    end else if (running) begin
      cycle_count <= cnt_next;
      if (partial)
        bad_write <= 1'b1;
      // A commit on the same edge as the watchdog expiry wins.
      if (commit) begin
        done <= 1'b1;
        if (mem_wdata == 32'd1) begin
          state <= S_PASS;
          pass  <= 1'b1;
        end else begin
          state     <= S_FAIL;
          fail_test <= mem_wdata[0] ? mem_wdata[31:1] : 31'h7FFF_FFFF;
        end
      end else if (expire) begin
        state <= S_TIMEOUT;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed and randomized checks of tohost_monitor against a verdict-level reference model.
module tb_tohost_monitor;
  localparam int TO_CYC = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic        done, pass, timeout, bad_write;
  logic [30:0] fail_test;
  logic [31:0] cycle_count;

  int total = 0;
  int bad = 0;

  // Reference model: verdict so far, as plain variables.
  bit          m_ended, m_pass, m_to, m_bw;
  logic [30:0] m_ft;
  longint      m_cnt;

  tohost_monitor #(.TOHOST_ADDR(32'h0000_1000), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .done(done), .pass(pass), .fail_test(fail_test),
    .timeout(timeout), .bad_write(bad_write), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic bit to_en();
`ifdef TOHOST_MONITOR_TIMEOUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit to_word;
    if (rst) begin
      m_ended = 0; m_pass = 0; m_to = 0; m_bw = 0; m_ft = '0; m_cnt = 0;
      return;
    end
    if (m_ended) return;
    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    to_word = mem_we && (mem_addr >> 2) == (32'h1000 >> 2) && mem_wdata != 0;
    if (to_word && mem_wstrb == 4'hF) begin
      m_ended = 1;
      if (mem_wdata == 1) m_pass = 1;
      else if (mem_wdata % 2 == 1) m_ft = mem_wdata / 2;
      else m_ft = 31'h7FFF_FFFF;
      return;
    end
    if (to_word && mem_wstrb != 0) m_bw = 1;
    if (to_en() && m_cnt == TO_CYC) begin
      m_ended = 1; m_to = 1;
    end
  endtask

  // Drive one cycle of inputs, clock it, update model, leave time at posedge+1.
  task automatic cyc(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    rst = r; mem_we = we; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 1, 32'h1000, 32'h1, 4'hF);
    total++;
    if ({done, pass, timeout, bad_write} !== 4'b0 || fail_test !== 31'd0 || cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL reset: done=%b pass=%b to=%b bw=%b ft=%0d cnt=%0d, want all 0",
               done, pass, timeout, bad_write, fail_test, cycle_count);
    end
  endtask

  task automatic test_pass();
    cyc(1, 0, 0, 0, 0);
    idle(10);
    cyc(0, 1, 32'h1000, 32'h1, 4'hF);
    total++;
    if (done !== 1 || pass !== 1 || fail_test !== 0 || timeout !== 0 || cycle_count !== 32'd11) begin
      bad++;
      $display("FAIL pass: done=%b pass=%b ft=%0d to=%b cnt=%0d, want 1 1 0 0 11",
               done, pass, fail_test, timeout, cycle_count);
    end
    idle(3);
    total++;
    if (cycle_count !== 32'd11 || done !== 1) begin
      bad++;
      $display("FAIL pass_hold: cnt=%0d done=%b, want 11 1", cycle_count, done);
    end
  endtask

  task automatic test_fail();
    cyc(1, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 32'h1000, 32'h7, 4'hF);
    total++;
    if (done !== 1 || pass !== 0 || fail_test !== 31'd3) begin
      bad++;
      $display("FAIL fail_num: done=%b pass=%b ft=%0d, want 1 0 3", done, pass, fail_test);
    end
    idle(1);
    cyc(0, 1, 32'h1000, 32'h1, 4'hF);
    cyc(0, 1, 32'h1000, 32'h5, 4'h1);
    total++;
    if (done !== 1 || pass !== 0 || fail_test !== 31'd3 || bad_write !== 0 || cycle_count !== 32'd3) begin
      bad++;
      $display("FAIL fail_terminal: done=%b pass=%b ft=%0d bw=%b cnt=%0d, want 1 0 3 0 3",
               done, pass, fail_test, bad_write, cycle_count);
    end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'h1000, 32'h10, 4'hF);
    total++;
    if (done !== 1 || fail_test !== 31'h7FFF_FFFF) begin
      bad++;
      $display("FAIL malformed: done=%b ft=%h, want 1 7fffffff", done, fail_test);
    end
  endtask

  task automatic test_bad_write();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'h1002, 32'h1, 4'h3);
    total++;
    if (bad_write !== 1 || done !== 0) begin
      bad++;
      $display("FAIL partial: bw=%b done=%b, want 1 0", bad_write, done);
    end
    cyc(0, 1, 32'h1000, 32'h1, 4'hF);
    total++;
    if (pass !== 1 || done !== 1 || bad_write !== 1) begin
      bad++;
      $display("FAIL partial_then_full: pass=%b done=%b bw=%b, want 1 1 1", pass, done, bad_write);
    end
  endtask

  task automatic test_ignored_and_rst();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'h1004, 32'h1, 4'hF);
    cyc(0, 1, 32'h1000, 32'h1, 4'h0);
    cyc(0, 1, 32'h1000, 32'h0, 4'h3);
    total++;
    if (done !== 0 || bad_write !== 0 || cycle_count !== 32'd3) begin
      bad++;
      $display("FAIL ignored: done=%b bw=%b cnt=%0d, want 0 0 3", done, bad_write, cycle_count);
    end
    cyc(0, 1, 32'h1003, 32'h1, 4'hF);
    total++;
    if (pass !== 1) begin
      bad++;
      $display("FAIL offset_hit: pass=%b, want 1", pass);
    end
    cyc(1, 0, 0, 0, 0);
    total++;
    if ({done, pass, timeout, bad_write} !== 4'b0 || cycle_count !== 0 || fail_test !== 0) begin
      bad++;
      $display("FAIL rst_in_pass: done=%b pass=%b cnt=%0d, want 0 0 0", done, pass, cycle_count);
    end
    idle(2);
    total++;
    if (cycle_count !== 32'd2 || done !== 0) begin
      bad++;
      $display("FAIL run_resumes: cnt=%0d done=%b, want 2 0", cycle_count, done);
    end
  endtask

  task automatic test_timeout();
    cyc(1, 0, 0, 0, 0);
    if (to_en()) begin
      idle(TO_CYC - 1);
      total++;
      if (done !== 0) begin
        bad++;
        $display("FAIL before_timeout: done=%b, want 0", done);
      end
      idle(1);
      total++;
      if (done !== 1 || timeout !== 1 || pass !== 0 || cycle_count !== TO_CYC) begin
        bad++;
        $display("FAIL timeout: done=%b to=%b pass=%b cnt=%0d, want 1 1 0 %0d",
                 done, timeout, pass, cycle_count, TO_CYC);
      end
      // Commit on the expiry edge beats the watchdog.
      cyc(1, 0, 0, 0, 0);
      idle(TO_CYC - 1);
      cyc(0, 1, 32'h1000, 32'h1, 4'hF);
      total++;
      if (pass !== 1 || timeout !== 0) begin
        bad++;
        $display("FAIL commit_priority: pass=%b to=%b, want 1 0", pass, timeout);
      end
    end else begin
      idle(100);
      total++;
      if (done !== 0 || timeout !== 0 || cycle_count !== 32'd100) begin
        bad++;
        $display("FAIL no_watchdog: done=%b to=%b cnt=%0d, want 0 0 100", done, timeout, cycle_count);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int t = 0; t < 40; t++) begin
      cyc(1, $urandom_range(0, 1), 32'h1000, 32'h1, 4'hF);
      for (int c = 0; c < 30; c++) begin
        case ($urandom_range(0, 3))
          0: a = 32'h1000;
          1: a = 32'h1000 | $urandom_range(0, 3);
          2: a = 32'h1004;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0: d = 32'h1;
          1: d = $urandom | 32'h1;
          2: d = $urandom & 32'hFFFF_FFFE;
          3: d = 32'h0;
          default: d = $urandom;
        endcase
        s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0), a, d, s);
        total++;
        if (done !== m_ended || pass !== m_pass || timeout !== m_to || bad_write !== m_bw ||
            fail_test !== m_ft || cycle_count !== 32'(m_cnt)) begin
          bad++;
          $display("FAIL random t=%0d c=%0d: got d=%b p=%b to=%b bw=%b ft=%h cnt=%0d want d=%b p=%b to=%b bw=%b ft=%h cnt=%0d",
                   t, c, done, pass, timeout, bad_write, fail_test, cycle_count,
                   m_ended, m_pass, m_to, m_bw, m_ft, m_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_bad_write();
    test_ignored_and_rst();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
